// File: rtl/ifft_8_serial.sv
// 8-point radix-2 DIT inverse FFT with serial load, one butterfly per clock, serial unload.
// Each butterfly halves its outputs, so the three stages together give the 1/8 IDFT scale.
module ifft_8_serial #(
  parameter int W       = 9,
  parameter int TW_FRAC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [2:0]          out_idx,
  output logic                out_last
);
  localparam int TW = TW_FRAC + 2;
  localparam int PW = W + TW + 1;
  localparam logic signed [TW-1:0] TW_ONE = TW'(1 << TW_FRAC);
  // cos(pi/4) scaled by 2^TW_FRAC, rounded to nearest
  localparam logic signed [TW-1:0] TW_R   = TW'(((1 << TW_FRAC) * 46341 + 32768) / 65536);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       armed;
  logic       in_fire, out_fire, cnt_adv;

  logic signed [W-1:0] mem_re [8];
  logic signed [W-1:0] mem_im [8];

  // armed keeps in_ready low until the first edge after reset is released
  assign in_ready  = armed && (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cnt_adv   = in_fire || out_fire || (state == COMPUTE);

  assign out_idx  = out_valid ? cnt[2:0] : 3'd0;
  assign out_re   = out_valid ? mem_re[cnt[2:0]] : '0;
  assign out_im   = out_valid ? mem_im[cnt[2:0]] : '0;
  assign out_last = out_valid && (cnt[2:0] == 3'd7);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && cnt == 4'd7)  state_nxt = COMPUTE;
      COMPUTE: if (cnt == 4'd11)            state_nxt = OUTPUT;
      OUTPUT:  if (out_fire && cnt == 4'd7) state_nxt = LOAD;
      default:                              state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state_nxt != state) cnt <= '0;
      else if (cnt_adv)       cnt <= cnt + 4'd1;
    end
  end

  // Butterfly schedule: cnt[3:2] is the stage, cnt[1:0] walks groups then offsets.
  logic [1:0] stage, bf, m;
  logic [2:0] top, bot;

  assign stage = cnt[3:2];
  assign bf    = cnt[1:0];

  always_comb begin
    top = {bf, 1'b0};
    bot = {bf, 1'b1};
    m   = 2'd0;
    case (stage)
      2'd1: begin
        top = {bf[1], 1'b0, bf[0]};
        bot = {bf[1], 1'b1, bf[0]};
        m   = {bf[0], 1'b0};
      end
      2'd2: begin
        top = {1'b0, bf};
        bot = {1'b1, bf};
        m   = bf;
      end
      default: ;
    endcase
  end

  // Conjugate twiddles W^-m = exp(+j*2*pi*m/8)
  logic signed [TW-1:0] w_re, w_im;

  always_comb begin
    w_re = TW_ONE;
    w_im = '0;
    case (m)
      2'd1: begin w_re = TW_R;   w_im = TW_R;   end
      2'd2: begin w_re = '0;     w_im = TW_ONE; end
      2'd3: begin w_re = -TW_R;  w_im = TW_R;   end
      default: ;
    endcase
  end

  logic signed [W-1:0]  a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] pf_re, pf_im;
  logic signed [W:0]    p_re, p_im, s_re, s_im, d_re, d_im;

  assign a_re = mem_re[top];
  assign a_im = mem_im[top];
  assign b_re = mem_re[bot];
  assign b_im = mem_im[bot];

  assign pf_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
  assign pf_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
  assign p_re  = (W+1)'(pf_re >>> TW_FRAC);
  assign p_im  = (W+1)'(pf_im >>> TW_FRAC);
  assign s_re  = (W+1)'(a_re) + p_re;
  assign s_im  = (W+1)'(a_im) + p_im;
  assign d_re  = (W+1)'(a_re) - p_re;
  assign d_im  = (W+1)'(a_im) - p_im;

  // NOTE: the sample buffer has no reset; an aborted frame is simply overwritten by the next load.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_re;
      mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[top] <= W'(s_re >>> 1);
      mem_im[top] <= W'(s_im >>> 1);
      mem_re[bot] <= W'(d_re >>> 1);
      mem_im[bot] <= W'(d_im >>> 1);
    end
  end

endmodule

// File: tb/tb_ifft_8_serial.sv
// Randomised self-checking bench for ifft_8_serial: a loop-based integer IDFT model,
// directed frames with known answers, handshake stalls, input gaps and reset abort.
module tb_ifft_8_serial;
  localparam int W       = 9;
  localparam int TW_FRAC = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                in_ready, out_valid, out_last;
  logic signed [W-1:0] out_re, out_im;
  logic [2:0]          out_idx;

  ifft_8_serial #(.W(W), .TW_FRAC(TW_FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0, n_pass = 0;
  int  t_last_in = 0;
  bit  expect_ready = 1'b0;
  int  fr_re[8], fr_im[8];
  int  ex_re[8], ex_im[8];
  int  got_re[8], got_im[8];
  int  prev_re[8], prev_im[8];
  int  tw_re[4], tw_im[4];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // Textbook in-place DIT on bit-reversed input, each butterfly scaled by 1/2.
  task automatic run_model();
    int br[8], bi[8];
    for (int k = 0; k < 8; k++) begin
      br[rev3(k)] = fr_re[k];
      bi[rev3(k)] = fr_im[k];
    end
    for (int s = 1; s <= 3; s++) begin
      int h;
      h = 1 << (s - 1);
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int t, b, mm, pr, pi, ar, ai;
          t  = g + j;
          b  = t + h;
          mm = j * (8 >> s);
          pr = (br[b] * tw_re[mm] - bi[b] * tw_im[mm]) >>> TW_FRAC;
          pi = (br[b] * tw_im[mm] + bi[b] * tw_re[mm]) >>> TW_FRAC;
          ar = br[t];
          ai = bi[t];
          br[t] = (ar + pr) >>> 1;
          bi[t] = (ai + pi) >>> 1;
          br[b] = (ar - pr) >>> 1;
          bi[b] = (ai - pi) >>> 1;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      ex_re[n] = br[n];
      ex_im[n] = bi[n];
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = int'($urandom_range(200)) - 100;
      fr_im[k] = int'($urandom_range(200)) - 100;
    end
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic send_frame(input int gap_pct);
    int k, guard;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 400) begin
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      in_re    = in_valid ? W'(fr_re[k]) : W'($urandom);
      in_im    = in_valid ? W'(fr_im[k]) : W'($urandom);
      @(negedge clk);
      if (expect_ready) begin
        check("in_ready_rise", int'(in_ready), 1);
        expect_ready = 1'b0;
      end
      if (in_valid && in_ready) begin
        k++;
        if (k == 8) t_last_in = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (k < 8) check("load_timeout", k, 8);
  endtask

  // mode 0: always ready, 1: five-cycle stall at idx 3, 2: random ready
  task automatic receive_frame(input int mode);
    int  n, guard, stall, busy_bad, unstable, lat;
    int  h_re, h_im, h_idx;
    bit  held;
    n = 0; guard = 0; stall = 0; busy_bad = 0; unstable = 0; lat = -1; held = 1'b0;
    h_re = 0; h_im = 0; h_idx = 0;
    while (n < 8 && guard < 300) begin
      in_valid = 1'b1;
      in_re    = W'($urandom);
      in_im    = W'($urandom);
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(n == 3 && stall < 5);
          if (!out_ready) stall++;
        end
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      @(negedge clk);
      if (in_ready) busy_bad++;
      if (out_valid) begin
        if (lat < 0) begin
          lat = cyc - t_last_in;
          check("latency", lat, 13);
        end
        if (held && (int'(out_re) != h_re || int'(out_im) != h_im || int'(out_idx) != h_idx))
          unstable++;
        if (out_ready) begin
          check("out_idx", int'(out_idx), n);
          check("out_last", int'(out_last), int'(n == 7));
          got_re[n] = out_re;
          got_im[n] = out_im;
          n++;
          held = 1'b0;
        end else begin
          held  = 1'b1;
          h_re  = out_re;
          h_im  = out_im;
          h_idx = out_idx;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (n < 8) check("out_timeout", n, 8);
    check("in_ready_busy", busy_bad, 0);
    if (mode == 1) begin
      check("stall_cycles", stall, 5);
      check("stall_hold", unstable, 0);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("x_re[%0d]", i), got_re[i], ex_re[i]);
      check($sformatf("x_im[%0d]", i), got_im[i], ex_im[i]);
    end
    expect_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"},  int'(out_last),  0);
    check({tag, "_out_re"},    int'(out_re),    0);
    check({tag, "_out_im"},    int'(out_im),    0);
    check({tag, "_out_idx"},   int'(out_idx),   0);
  endtask

  initial begin
    real ang;
    int  sx, sy, seen_v;
    for (int m = 0; m < 4; m++) begin
      ang = 2.0 * 3.14159265358979 * m / 8.0;
      tw_re[m] = $rtoi($floor((1 << TW_FRAC) * $cos(ang) + 0.5));
      tw_im[m] = $rtoi($floor((1 << TW_FRAC) * $sin(ang) + 0.5));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_pre_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    expect_ready = 1'b1;

    // Impulse at k=0: flat output of 64/8
    clear_frame();
    fr_re[0] = 64;
    run_model();
    send_frame(0);
    receive_frame(0);
    for (int n = 0; n < 8; n++) begin
      check("impulse_re", got_re[n], 8);
      check("impulse_im", got_im[n], 0);
    end

    // Constant spectrum: impulse at n=0, sent with no gap after the previous frame
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 8;
      fr_im[k] = 0;
    end
    run_model();
    send_frame(0);
    receive_frame(0);
    for (int n = 0; n < 8; n++) begin
      check("dc_re", got_re[n], (n == 0) ? 8 : 0);
      check("dc_im", got_im[n], 0);
    end

    // Single bin k=1: a rotating phasor of magnitude 8
    clear_frame();
    fr_re[1] = 64;
    run_model();
    send_frame(0);
    receive_frame(0);
    check("bin1_x0_re", got_re[0], 8);
    check("bin1_x0_im", got_im[0], 0);
    check("bin1_x2_re", got_re[2], 0);
    check("bin1_x2_im", got_im[2], 8);
    check("bin1_x4_re", got_re[4], -8);
    check("bin1_x4_im", got_im[4], 0);
    check("bin1_x6_re", got_re[6], 0);
    check("bin1_x6_im", got_im[6], -8);
    for (int n = 1; n < 8; n += 2) begin
      sx = (n == 1 || n == 7) ? 1 : -1;
      sy = (n == 1 || n == 3) ? 1 : -1;
      check("bin1_odd_re_tol", int'((got_re[n] * 100 - sx * 566) <= 100 && (got_re[n] * 100 - sx * 566) >= -100), 1);
      check("bin1_odd_im_tol", int'((got_im[n] * 100 - sy * 566) <= 100 && (got_im[n] * 100 - sy * 566) >= -100), 1);
    end

    // Random frame with a downstream stall, then the same frame with gaps and random ready
    random_frame();
    run_model();
    send_frame(0);
    receive_frame(1);
    for (int n = 0; n < 8; n++) begin
      prev_re[n] = got_re[n];
      prev_im[n] = got_im[n];
    end
    send_frame(40);
    receive_frame(2);
    for (int n = 0; n < 8; n++) begin
      check("repeat_re", got_re[n], prev_re[n]);
      check("repeat_im", got_im[n], prev_im[n]);
    end

    // Abort a frame in the sixth compute cycle
    random_frame();
    send_frame(0);
    expect_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_pre", int'(in_ready), 0);
    seen_v = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen_v++;
    end
    check("abort_no_out_valid", seen_v, 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Back-to-back random frames with random gaps and downstream behaviour
    for (int f = 0; f < 6; f++) begin
      random_frame();
      run_model();
      send_frame(int'($urandom_range(50)));
      receive_frame(int'($urandom_range(2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
